data_memory_responder: RTL

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

---
 rtl/data_memory_responder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/data_memory_responder.sv
// Load/store responder: word memory plus one memory-mapped output byte, multi-cycle access FSM.
// Latency ACCESS_LATENCY+1 cycles from request to response_valid; illegal or busy requests only raise sticky flags.
module data_memory_responder #(
  parameter int          MEMORY_WORDS   = 1024,
  parameter int          ACCESS_LATENCY = 2,
  parameter logic [31:0] IO_ADDRESS     = 32'h0000_FFFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        request_valid,
  input  logic        request_is_store,
  input  logic [2:0]  subfunction_3,
  input  logic [31:0] address,
  input  logic [31:0] store_value,
  output logic        clk_stall,
  output logic        response_valid,
  output logic [31:0] load_result,
  output logic        load_error,
  output logic        store_error,
  output logic        protocol_error,
  output logic [7:0]  memory_mapped_io
);
  localparam int AW = (MEMORY_WORDS > 1) ? $clog2(MEMORY_WORDS) : 1;
  localparam int CW = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_next;

  logic [CW-1:0] count;
  logic [31:0]   mem [MEMORY_WORDS];

  logic          lat_store;
  logic          lat_io;
  logic [2:0]    lat_f3;
  logic [AW-1:0] lat_idx;
  logic [1:0]    lat_lane;
  logic [31:0]   lat_value;

  logic req_io, req_in_range, f3_legal, align_ok, req_legal;
  logic access_now;
  logic [31:0] word, lane_word, load_ext, wdata;
  logic [3:0]  be;

  always_comb begin
    req_io       = (address[31:2] == IO_ADDRESS[31:2]);
    req_in_range = ({2'b00, address[31:2]} < 32'(MEMORY_WORDS));
    case (subfunction_3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = !request_is_store;
      default:                f3_legal = 1'b0;
    endcase
    case (subfunction_3[1:0])
      2'b01:   align_ok = !address[0];
      2'b10:   align_ok = (address[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    req_legal = f3_legal && align_ok && (req_in_range || req_io);
  end

  assign access_now = (state == ACCESS) && (count == '0);

  // Load path works on the latched request; the IO word reads as the output byte zero-padded.
  always_comb begin
    word      = lat_io ? {24'h0, memory_mapped_io} : mem[lat_idx];
    lane_word = word >> {lat_lane, 3'b000};
    case (lat_f3)
      3'b000:  load_ext = {{24{lane_word[7]}}, lane_word[7:0]};
      3'b001:  load_ext = {{16{lane_word[15]}}, lane_word[15:0]};
      3'b100:  load_ext = {24'h0, lane_word[7:0]};
      3'b101:  load_ext = {16'h0, lane_word[15:0]};
      default: load_ext = word;
    endcase
    case (lat_f3[1:0])
      2'b00: begin
        wdata = {4{lat_value[7:0]}};
        be    = 4'b0001 << lat_lane;
      end
      2'b01: begin
        wdata = {2{lat_value[15:0]}};
        be    = lat_lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata = lat_value;
        be    = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (request_valid && req_legal) state_next = ACCESS;
      ACCESS:  if (count == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    clk_stall      = !reset && (((state == IDLE) && request_valid && req_legal) || (state == ACCESS));
    response_valid = !reset && (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      count            <= '0;
      load_result      <= '0;
      load_error       <= 1'b0;
      store_error      <= 1'b0;
      protocol_error   <= 1'b0;
      memory_mapped_io <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (request_valid && req_legal) begin
            count <= CW'(ACCESS_LATENCY - 1);
          end else if (request_valid) begin
            if (request_is_store) store_error <= 1'b1;
            else                  load_error  <= 1'b1;
          end
        end
        ACCESS: begin
          if (count != '0) begin
            count <= count - CW'(1);
          end else if (!lat_store) begin
            load_result <= load_ext;
          end else if (lat_io && be[0]) begin
            memory_mapped_io <= lat_value[7:0];
          end
          if (request_valid) protocol_error <= 1'b1;
        end
        default: begin
          if (request_valid) protocol_error <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && (state == IDLE) && request_valid && req_legal) begin
      lat_store <= request_is_store;
      lat_io    <= req_io;
      lat_f3    <= subfunction_3;
      lat_idx   <= address[AW+1:2];
      lat_lane  <= address[1:0];
      lat_value <= store_value;
    end
  end

  // Storage is never cleared; a reset on the write edge drops the store.
  always_ff @(posedge clk) begin
    if (!reset && access_now && lat_store && !lat_io) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[lat_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end
endmodule
